gate_bist: RTL
==============

Name: gate_bist

Overview:
- Synthesizable built-in self-test engine for small combinational gates; it replaces hand-written per-gate directed benches.
- Sweeps all 2^N_IN input vectors into an attached N-input gate, waits a programmable settle time per vector, and compares the gate output against a selected reference function.
- Reports error count, first failing vector and pass/fail.
- Sits beside any gate instance in the logic-gates library; one engine per DUT.

Parameters:
N_IN, 2, number of gate inputs (legal 1..8)
SETTLE, 1, extra cycles each vector is held before sampling (legal 0..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep (sampled in IDLE or DONE only)
abort  input  1  cancel a running sweep
mode  input  3  reference function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 illegal
dut_in  output  N_IN  vector driven to the gate under test
dut_out  input  1  gate under test output
busy  output  1  sweep in progress
done  output  1  sweep finished; results valid
pass  output  1  done and err_count==0 and mode legal
mode_err  output  1  last start used an illegal mode
err_count  output  N_IN+1  number of mismatching vectors (max 2^N_IN, cannot overflow)
first_fail_vec  output  N_IN  lowest vector that mismatched
first_fail_valid  output  1  first_fail_vec holds a real failure

Behaviour:
- Single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, internal vector and settle counters 0. Reset asserted mid-sweep aborts immediately and returns every output to 0.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1 with legal mode, at edge E0:
  - latch mode;
  - clear err_count, first_fail_*, done, pass, mode_err;
  - dut_in<=0, vec<=0, cnt<=SETTLE, busy<=1, go RUN.
- IDLE/DONE, start=1 with mode 6/7:
  - go DONE at the same edge;
  - mode_err=1, pass=0, err_count=0, busy never asserted.
- RUN, each edge:
  - cnt!=0: cnt decrements.
  - cnt==0 (sample edge): compute expected = reduction of dut_in per latched mode. Mismatch when dut_out != expected.
  - On mismatch, err_count increments. If first_fail_valid==0, also capture first_fail_vec<=dut_in and set first_fail_valid=1.
  - If vec==2^N_IN-1: busy<=0, done<=1, pass<=(no errors including this sample), go DONE.
  - Otherwise vec++, dut_in<=vec+1, cnt<=SETTLE.
- Each vector is held on dut_in for exactly SETTLE+1 cycles. Vector k is sampled at edge E0+(k+1)(SETTLE+1).
- done rises after edge E0+2^N_IN*(SETTLE+1).
- mode and dut_out changes outside a sample edge have no effect; mode is used only as latched at start.
- start while in RUN is ignored.
- abort in RUN (abort has priority over a simultaneous sample):
  - go IDLE; busy, done, pass and dut_in go to 0;
  - err_count and first_fail_* hold their partial values.
- abort in IDLE/DONE has no effect. start and abort together in IDLE/DONE: start wins.
- DONE holds all results stable until the next start or reset.
- N_IN=1 reductions degenerate: AND/OR/XOR = dut_in[0]; NAND/NOR/XNOR = ~dut_in[0].

Test Plan:
- N_IN=2, SETTLE=1, mode=2, ideal NAND model on dut_out; pulse start → dut_in steps 00,01,10,11, each held 2 cycles; done=1 exactly 8 cycles after the start edge; pass=1, err_count=0, first_fail_valid=0.
- Same config, dut_out stuck at 1 → err_count=1, first_fail_vec=2'b11, first_fail_valid=1, pass=0.
- N_IN=3, SETTLE=0, mode=4, model drives XNOR → err_count=8, first_fail_vec=3'b000, pass=0, done 8 cycles after start.
- mode=6 with start → next cycle done=1, mode_err=1, pass=0, busy stayed 0, dut_in=0.
- N_IN=2, SETTLE=2, ideal NOR with mode=3: re-pulse start at cycle 4 → ignored; abort at cycle 5 → busy=0, done=0, dut_in=0 next cycle. Fresh start then completes with pass=1.
- Assert rst_n=0 mid-sweep for 1 cycle, asynchronously between edges → all outputs 0 immediately; after release, start with mode=0 and an ideal AND model → pass=1.

Source files
------------

// File: rtl/gate_bist.sv
// Exhaustive self-test sweeper for a small N-input combinational gate.
// Drives every input vector, holds it SETTLE+1 cycles, compares against a reference.
module gate_bist #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      mode,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            mode_err,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [N_IN-1:0] LAST = '1;
    localparam logic [3:0]      SET  = 4'(SETTLE);

    state_t     state;
    logic [2:0] mode_q;
    logic [3:0] cnt;
    logic       expected;
    logic       miss;

    always_comb begin
        expected = 1'b0;
        case (mode_q)
            3'd0:    expected = &dut_in;
            3'd1:    expected = |dut_in;
            3'd2:    expected = ~&dut_in;
            3'd3:    expected = ~|dut_in;
            3'd4:    expected = ^dut_in;
            3'd5:    expected = ~^dut_in;
            default: expected = 1'b0;
        endcase
        miss = (dut_out != expected);
    end

    // dut_in doubles as the sweep vector counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            mode_q           <= '0;
            cnt              <= '0;
            dut_in           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mode_err         <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                        dut_in           <= '0;
                        cnt              <= SET;
                        if (mode >= 3'd6) begin
                            mode_err <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= DONE;
                        end else begin
                            mode_q   <= mode;
                            mode_err <= 1'b0;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b0;
                        pass   <= 1'b0;
                        dut_in <= '0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (miss) begin
                            err_count <= err_count + 1'b1;
                            if (!first_fail_valid) begin
                                first_fail_vec   <= dut_in;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        if (dut_in == LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == '0) && !miss;
                            state <= DONE;
                        end else begin
                            dut_in <= dut_in + 1'b1;
                            cnt    <= SET;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
